mem_interface: RTL and testbench
================================

Name: mem_interface

Overview:
- MAR/MDR front end for the 512x32 memory block.
- Latches the address (MAR) and data (MDR) from the CPU bus.
- Sequences single-word read/write transactions to memory with a req/done handshake.
- Returns read data to the bus through MDR.
- Sits between the datapath bus/control unit (upstream) and the memory array (downstream).

Parameters:
ADDR_W, 9, memory address width (512 words)
DATA_W, 32, bus/memory word width

Ports:
clk  input  1  system clock, all state on rising edge
clear  input  1  reset, asynchronous, active-low
bus_in  input  DATA_W  CPU bus value
MAR_in  input  1  load MAR from bus_in[ADDR_W-1:0]
MDR_in  input  1  load MDR from bus_in
mem_req  input  1  start a memory transaction (sampled only in IDLE)
mem_we  input  1  transaction type with mem_req: 1=write, 0=read
mem_rdata  input  DATA_W  memory Dataout (combinational read of mem_addr)
mem_addr  output  ADDR_W  memory Address = MAR
mem_wdata  output  DATA_W  memory Datain = MDR
mem_write  output  1  memory Write strobe
MDR_out  output  DATA_W  MDR contents to bus driver
busy  output  1  high whenever state != IDLE
mem_done  output  1  one-cycle completion pulse
addr_err  output  1  sticky: MAR load with bus_in[DATA_W-1:ADDR_W] != 0

Behaviour:
- clear low (async): state=IDLE, MAR=0, MDR=0, mem_write=0, mem_done=0, busy=0, addr_err=0.
- Takes effect immediately, including mid-transaction. An in-flight write is dropped; the strobe falls with clear.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - mem_req=1, mem_we=0 -> RD.
  - mem_req=1, mem_we=1 -> WR.
  - Otherwise stay in IDLE.
- RD (1 cycle): mem_addr=MAR. At the closing edge, MDR <= mem_rdata. -> DONE.
- WR (1 cycle): mem_write=1, mem_wdata=MDR. Memory commits at the closing edge. -> DONE.
- DONE (1 cycle): mem_done=1. -> IDLE.
- Transaction latency: req sampled at edge N; mem_done high during cycle N+2; new req accepted at edge N+3.
- mem_write and mem_done are decoded from state (Moore), glitch-free, high only in WR/DONE respectively.
- MAR_in/MDR_in are honoured only in IDLE. While busy they are ignored (no effect, no error); the control unit must wait for mem_done.
- Same-edge in IDLE:
  - MAR_in with mem_req: the transaction uses the newly loaded address (RD/WR occur next cycle).
  - MDR_in with a write req: the new MDR is written.
- MAR takes bus_in[ADDR_W-1:0]. Upper bits are truncated (wrap modulo 512).
- If upper bits are non-zero on a MAR load, addr_err sets and holds until clear.
- mem_req while not IDLE is ignored and not queued.
- MDR_out is always the registered MDR, never combinational from mem_rdata.

Decomposition:
- Shared package: ADDR_W, DATA_W, MEM_DEPTH=512, and the state encoding enum (IDLE=2'd0, RD=2'd1, WR=2'd2, DONE=2'd3).
- One natural sub-module: mdr_reg (DATA_W register with async active-low clear, selecting bus_in vs mem_rdata with separate load enables). MAR stays inline.

Test Plan:
- Reset: drive clear low mid-WR with mem_write=1 -> all outputs 0 immediately; state IDLE after release; memory word unchanged.
- Write/read-back:
  - MAR_in with bus_in=0x005, then MDR_in with 0xDEADBEEF, then mem_req, mem_we=1 -> mem_write high exactly 1 cycle with mem_addr=5 and mem_wdata=0xDEADBEEF; mem_done pulses 1 cycle later.
  - Then mem_req, mem_we=0 -> MDR_out=0xDEADBEEF in the DONE cycle.
- Same-edge load and request: MAR_in with bus_in=0x1FF together with mem_req (read) -> RD uses mem_addr=0x1FF; MDR gets memory[511].
- Busy lockout: during RD, pulse MDR_in with 0x12345678, MAR_in with 0x003, and mem_req -> MDR ends at the read value; MAR stays unchanged; exactly one mem_done pulse.
- Address overflow: MAR_in with bus_in=0x00000205 -> mem_addr=0x005, addr_err=1 and stays 1 after subsequent valid loads until clear.
- Back-to-back: hold mem_req=1 with alternating mem_we -> transactions start every 3 cycles; busy low for exactly the IDLE cycle between them.

Source files
------------

// File: rtl/mem_interface_pkg.sv
// Shared widths and controller state encoding for the MAR/MDR memory front end.
package mem_interface_pkg;

  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned ADDR_W    = $clog2(MEM_DEPTH);
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_interface_mdr_reg.sv
// Memory data register: loads from the CPU bus or from memory read data.
module mem_interface_mdr_reg
  import mem_interface_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              load_bus,
  input  logic              load_mem,
  output logic [DATA_W-1:0] q
);

  // The two loads never overlap (bus in IDLE, memory in RD); bus wins if they ever do.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q <= '0;
    end else if (load_bus) begin
      q <= bus_in;
    end else if (load_mem) begin
      q <= mem_rdata;
    end
  end

endmodule

// File: rtl/mem_interface.sv
// MAR/MDR front end sequencing single-word read/write transactions with a req/done handshake.
module mem_interface
  import mem_interface_pkg::*;
(
  input  logic              clk,
  input  logic              clear,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              MAR_in,
  input  logic              MDR_in,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic [DATA_W-1:0] MDR_out,
  output logic              busy,
  output logic              mem_done,
  output logic              addr_err
);

  state_e            state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              idle_c;
  logic              mar_load_c;
  logic              mdr_load_c;
  logic              rd_load_c;

  assign idle_c     = (state == IDLE);
  assign mar_load_c = idle_c && MAR_in;
  assign mdr_load_c = idle_c && MDR_in;
  assign rd_load_c  = (state == RD);

  // MAR: honoured only in IDLE; upper bus bits are dropped but flagged.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mar      <= '0;
      addr_err <= 1'b0;
    end else if (mar_load_c) begin
      mar <= bus_in[ADDR_W-1:0];
      if (|bus_in[DATA_W-1:ADDR_W]) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Controller: strobes are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      mem_write <= 1'b0;
      mem_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            busy <= 1'b1;
            if (mem_we) begin
              state     <= WR;
              mem_write <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state    <= DONE;
          mem_done <= 1'b1;
        end
        WR: begin
          state     <= DONE;
          mem_write <= 1'b0;
          mem_done  <= 1'b1;
        end
        DONE: begin
          state    <= IDLE;
          mem_done <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_write <= 1'b0;
          mem_done  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  mem_interface_mdr_reg u_mdr (
    .clk       (clk),
    .clear     (clear),
    .bus_in    (bus_in),
    .mem_rdata (mem_rdata),
    .load_bus  (mdr_load_c),
    .load_mem  (rd_load_c),
    .q         (mdr)
  );

  assign mem_addr  = mar;
  assign mem_wdata = mdr;
  assign MDR_out   = mdr;

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface with a behavioural 512x32 memory.
module tb_mem_interface;
  import mem_interface_pkg::*;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              clear;
  logic [DATA_W-1:0] bus_in;
  logic              MAR_in, MDR_in, mem_req, mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] MDR_out;
  logic              busy, mem_done, addr_err;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  exp_t              sb[$];
  int                checks = 0;
  int                errors = 0;
  int                wr_cycles = 0;
  int                done_cnt = 0;
  logic [ADDR_W-1:0] seen_addr;
  logic [DATA_W-1:0] seen_wdata;

  always #5 clk = ~clk;

  mem_interface dut (
    .clk       (clk),
    .clear     (clear),
    .bus_in    (bus_in),
    .MAR_in    (MAR_in),
    .MDR_in    (MDR_in),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .MDR_out   (MDR_out),
    .busy      (busy),
    .mem_done  (mem_done),
    .addr_err  (addr_err)
  );

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_t e;
    e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endtask

  // Monitor: tracks strobes and retires one scoreboard entry per mem_done pulse.
  always @(negedge clk) begin
    if (clear) begin
      if (mem_write) begin
        wr_cycles++;
        seen_addr  = mem_addr;
        seen_wdata = mem_wdata;
      end else if (busy && !mem_done) begin
        seen_addr = mem_addr;
      end
      if (mem_done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got pulse expected none at %0t", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("txn_addr", DATA_W'(seen_addr), DATA_W'(e.addr));
          chk(e.we ? "txn_wdata" : "txn_rdata", e.we ? seen_wdata : MDR_out, e.data);
        end
      end
    end
  end

  initial begin
    int wr0, d0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] = 32'h0;
    mem[511] = 32'hCAFE_F00D;
    mem[10]  = 32'h1111_2222;
    clear = 1'b0; bus_in = '0; MAR_in = 0; MDR_in = 0; mem_req = 0; mem_we = 0;

    #3;
    chk("rst_busy", DATA_W'(busy), 0);
    chk("rst_done", DATA_W'(mem_done), 0);
    chk("rst_write", DATA_W'(mem_write), 0);
    chk("rst_mdr", MDR_out, 0);
    cyc();
    clear = 1'b1;

    // Write 0xDEADBEEF to address 5.
    MAR_in = 1; bus_in = 32'h005; cyc();
    MAR_in = 0; MDR_in = 1; bus_in = 32'hDEAD_BEEF; cyc();
    MDR_in = 0; mem_req = 1; mem_we = 1;
    push(1'b1, 9'h005, 32'hDEAD_BEEF);
    wr0 = wr_cycles;
    cyc();
    mem_req = 0; mem_we = 0;
    repeat (3) cyc();
    chk("wr_strobe_cycles", DATA_W'(wr_cycles - wr0), 1);
    chk("mem5_written", mem[5], 32'hDEAD_BEEF);

    // Read it back.
    mem_req = 1; mem_we = 0;
    push(1'b0, 9'h005, 32'hDEAD_BEEF);
    cyc();
    mem_req = 0;
    repeat (3) cyc();

    // MAR load on the same edge as a read request.
    MAR_in = 1; bus_in = 32'h1FF; mem_req = 1; mem_we = 0;
    push(1'b0, 9'h1FF, 32'hCAFE_F00D);
    cyc();
    MAR_in = 0; mem_req = 0;
    repeat (3) cyc();

    // Loads and requests while busy are ignored.
    MAR_in = 1; bus_in = 32'h00A; cyc();
    MAR_in = 0;
    d0 = done_cnt;
    mem_req = 1;
    push(1'b0, 9'h00A, 32'h1111_2222);
    cyc();
    MDR_in = 1; bus_in = 32'h1234_5678; cyc();
    MDR_in = 0; MAR_in = 1; bus_in = 32'h003; cyc();
    MAR_in = 0; mem_req = 0;
    repeat (2) cyc();
    chk("lock_mdr", MDR_out, 32'h1111_2222);
    chk("lock_mar", DATA_W'(mem_addr), 32'h00A);
    chk("lock_done_pulses", DATA_W'(done_cnt - d0), 1);
    chk("lock_busy", DATA_W'(busy), 0);

    // Address overflow wraps and sets a sticky flag.
    MAR_in = 1; bus_in = 32'h0000_0205; cyc();
    MAR_in = 0;
    chk("ovf_addr", DATA_W'(mem_addr), 32'h005);
    chk("ovf_err", DATA_W'(addr_err), 1);
    MAR_in = 1; bus_in = 32'h00A; cyc();
    MAR_in = 0;
    chk("ovf_err_sticky", DATA_W'(addr_err), 1);

    // Clear mid-write drops the strobe and the write.
    MDR_in = 1; bus_in = 32'h55AA_55AA; cyc();
    MDR_in = 0; mem_req = 1; mem_we = 1; cyc();
    mem_req = 0; mem_we = 0;
    chk("midwr_strobe", DATA_W'(mem_write), 1);
    clear = 1'b0;
    #1;
    chk("clr_write", DATA_W'(mem_write), 0);
    chk("clr_busy", DATA_W'(busy), 0);
    chk("clr_done", DATA_W'(mem_done), 0);
    chk("clr_err", DATA_W'(addr_err), 0);
    chk("clr_mdr", MDR_out, 0);
    chk("clr_addr", DATA_W'(mem_addr), 0);
    cyc();
    chk("clr_mem_kept", mem[10], 32'h1111_2222);
    clear = 1'b1;
    cyc();
    chk("clr_idle_busy", DATA_W'(busy), 0);

    // Back-to-back with mem_req held and mem_we alternating.
    MAR_in = 1; bus_in = 32'h007; cyc();
    MAR_in = 0; MDR_in = 1; bus_in = 32'hA5A5_A5A5; cyc();
    MDR_in = 0;
    push(1'b1, 9'h007, 32'hA5A5_A5A5);
    push(1'b0, 9'h007, 32'hA5A5_A5A5);
    push(1'b1, 9'h007, 32'hA5A5_A5A5);
    push(1'b0, 9'h007, 32'hA5A5_A5A5);
    mem_req = 1; mem_we = 1;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk($sformatf("b2b_busy_%0d", k), DATA_W'(busy), DATA_W'((k % 3) != 2));
      if ((k % 3) == 2) begin
        mem_we = ~mem_we;
        if (k == 11) mem_req = 0;
      end
      @(posedge clk);
    end
    #1;
    mem_req = 0; mem_we = 0;
    repeat (4) cyc();

    chk("sb_drained", DATA_W'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
